focus_sharpness_acc: RTL

- Per-frame sharpness (high-frequency energy) measurement over a centred focus window of the live video stream.
- Sits directly upstream of the VCM step controller in the autofocus path.
- Consumes pixel data, negative-pulse VS and the LCD H/V counters.
- Produces one sharpness figure per frame plus a valid strobe; the controller hill-climbs on it.

---
 rtl/focus_sharpness_if.sv | 31 +++
 rtl/focus_sharpness_acc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/focus_sharpness_if.sv
// Video-side bundle for the autofocus sharpness meter: pixel stream and
// window counters in, per-frame sharpness figures out.
interface focus_sharpness_if #(
    parameter int ACC_W = 32
);
    logic             VS;
    logic             VIDEO_DE;
    logic [15:0]      H_CNT;
    logic [15:0]      V_CNT;
    logic [7:0]       iR;
    logic [7:0]       iG;
    logic [7:0]       iB;
    logic             MODE;
    logic [7:0]       THRESH;
    logic             PEAK_CLR;
    logic [ACC_W-1:0] SHARP;
    logic             SHARP_VALID;
    logic [ACC_W-1:0] PEAK;
    logic [19:0]      PIX_CNT;
    logic [7:0]       FRAME_CNT;

    modport master (
        output VS, VIDEO_DE, H_CNT, V_CNT, iR, iG, iB, MODE, THRESH, PEAK_CLR,
        input  SHARP, SHARP_VALID, PEAK, PIX_CNT, FRAME_CNT
    );

    modport slave (
        input  VS, VIDEO_DE, H_CNT, V_CNT, iR, iG, iB, MODE, THRESH, PEAK_CLR,
        output SHARP, SHARP_VALID, PEAK, PIX_CNT, FRAME_CNT
    );
endinterface

// File: rtl/focus_sharpness_acc.sv
// Per-frame high-frequency energy over a centred focus window; feeds the
// VCM hill-climbing controller with one sharpness figure per frame.
module focus_sharpness_acc #(
    parameter int WIN_X0 = 240,
    parameter int WIN_W  = 160,
    parameter int WIN_Y0 = 180,
    parameter int WIN_H  = 120,
    parameter int ACC_W  = 32
) (
    input logic              VIDEO_CLK,
    input logic              RESET_N,
    focus_sharpness_if.slave vid
);
    localparam logic [16:0] X_LO = 17'(WIN_X0);
    localparam logic [16:0] X_HI = 17'(WIN_X0 + WIN_W);
    localparam logic [16:0] Y_LO = 17'(WIN_Y0);
    localparam logic [16:0] Y_HI = 17'(WIN_Y0 + WIN_H);

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

    function automatic logic [9:0] grad_first(input logic [7:0] cur, input logic [7:0] prev);
        logic [7:0] mag;
        mag = (cur >= prev) ? (cur - prev) : (prev - cur);
        return {2'b00, mag};
    endfunction

    function automatic logic [9:0] grad_second(input logic [7:0] cur, input logic [7:0] prev1,
                                               input logic [7:0] prev2);
        logic signed [10:0] lap;
        logic [10:0]        mag;
        lap = signed'({2'b00, prev1, 1'b0}) - signed'({3'b000, cur})
            - signed'({3'b000, prev2});
        mag = (lap < 0) ? 11'(-lap) : 11'(lap);
        return (mag > 11'd1023) ? 10'd1023 : mag[9:0];
    endfunction

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                                 input logic [9:0] g);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W-9){1'b0}}, g};
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    function automatic logic [19:0] sat_cnt(input logic [19:0] c);
        return (c == 20'hFFFFF) ? c : c + 20'd1;
    endfunction

    logic             in_win, in_win_d;
    logic [7:0]       y_p1;
    logic             vld_p1, start_p1;
    logic [7:0]       hist1, hist2;
    logic [1:0]       hist_n;
    logic [9:0]       grad_p2;
    logic             vld_p2;
    logic             grad_ok, hit, vs_d, vs_fall, armed;
    logic             mode_f;
    logic [7:0]       thresh_f;
    logic [ACC_W-1:0] acc, sharp, peak;
    logic [19:0]      cnt, pix_cnt;
    logic             sharp_valid;
    logic [7:0]       frame_cnt;

    assign in_win = vid.VIDEO_DE
                 && ({1'b0, vid.H_CNT} >= X_LO) && ({1'b0, vid.H_CNT} < X_HI)
                 && ({1'b0, vid.V_CNT} >= Y_LO) && ({1'b0, vid.V_CNT} < Y_HI);

    // A restart (IN_WIN rising) discards history so gradients never span lines.
    assign grad_ok = vld_p1 && !start_p1
                  && (mode_f ? (hist_n == 2'd2) : (hist_n != 2'd0));
    assign hit     = vld_p2 && (grad_p2 > {2'b00, thresh_f});
    assign vs_fall = vs_d && !vid.VS;

    // Stage 1: luma
    always_ff @(posedge VIDEO_CLK) begin
        y_p1 <= luma(vid.iR, vid.iG, vid.iB);
    end

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            in_win_d <= 1'b0;
            vld_p1   <= 1'b0;
            start_p1 <= 1'b0;
        end else begin
            in_win_d <= in_win;
            vld_p1   <= in_win;
            start_p1 <= in_win && !in_win_d;
        end
    end

    // Stage 2: gradient against line history
    always_ff @(posedge VIDEO_CLK) begin
        if (vld_p1) begin
            hist1 <= y_p1;
            hist2 <= hist1;
        end
        grad_p2 <= mode_f ? grad_second(y_p1, hist1, hist2) : grad_first(y_p1, hist1);
    end

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hist_n <= 2'd0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= grad_ok;
            if (vld_p1) begin
                if (start_p1)            hist_n <= 2'd1;
                else if (hist_n != 2'd2) hist_n <= hist_n + 2'd1;
            end
        end
    end

    // Stage 3: threshold, accumulate, frame boundary
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_d        <= 1'b0;
            armed       <= 1'b0;
            mode_f      <= 1'b0;
            thresh_f    <= 8'd0;
            acc         <= '0;
            cnt         <= 20'd0;
            sharp       <= '0;
            pix_cnt     <= 20'd0;
            sharp_valid <= 1'b0;
            frame_cnt   <= 8'd0;
            peak        <= '0;
        end else begin
            vs_d        <= vid.VS;
            sharp_valid <= vs_fall && armed;
            if (vs_fall) begin
                if (armed) begin
                    sharp     <= acc;
                    pix_cnt   <= cnt;
                    frame_cnt <= frame_cnt + 8'd1;
                end
                // A gradient landing on the boundary belongs to the new frame.
                acc      <= hit ? {{(ACC_W-10){1'b0}}, grad_p2} : '0;
                cnt      <= hit ? 20'd1 : 20'd0;
                armed    <= 1'b1;
                mode_f   <= vid.MODE;
                thresh_f <= vid.THRESH;
            end else if (hit) begin
                acc <= sat_acc(acc, grad_p2);
                cnt <= sat_cnt(cnt);
            end
            if (vid.PEAK_CLR)                     peak <= '0;
            else if (sharp_valid && sharp > peak) peak <= sharp;
        end
    end

    assign vid.SHARP       = sharp;
    assign vid.SHARP_VALID = sharp_valid;
    assign vid.PEAK        = peak;
    assign vid.PIX_CNT     = pix_cnt;
    assign vid.FRAME_CNT   = frame_cnt;
endmodule
